// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the PC update slice.
//   pc_state_t      : sequencer states BOOT / RUN / STALL
//   PC_STEP         : byte increment for sequential fetch
//   OFFSET_W        : width of the signed word offset
//   redirect_taken(): JUMP / BEQ / BNE redirect decision
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } pc_state_t;

    localparam int unsigned PC_STEP  = 4;
    localparam int unsigned OFFSET_W = 8;

    // JUMP wins over everything. BEQ is checked before BNE, so asserting
    // both behaves as BEQ alone: BNE only counts when BEQ is low.
    function automatic logic redirect_taken(
        input logic jump,
        input logic beq,
        input logic bne,
        input logic zero
    );
        logic r;
        r = 1'b0;
        if (jump)
            r = 1'b1;
        else if (beq)
            r = zero;
        else if (bne)
            r = ~zero;
        return r;
    endfunction

endpackage

// File: rtl/pc_update_unit_if.sv
// pc_update_unit_if -- control/address bundle between the fetch sequencer
// and its environment.
//   BUSYWAIT  : memory stall, holds PC and state while high
//   JUMP      : unconditional PC-relative jump request
//   BEQ / BNE : branch-if-zero / branch-if-not-zero requests
//   ZERO      : ALU zero flag
//   OFFSET    : signed word offset (two's complement)
//   PC        : current instruction address
//   PC_VALID  : PC is a fetchable address
//   TAKEN     : one-cycle pulse after a redirect updated PC
// modport master : environment side (drives controls, observes PC)
// modport slave  : pc_update_unit side
interface pc_update_unit_if;
    import pc_pkg::*;

    logic                BUSYWAIT;
    logic                JUMP;
    logic                BEQ;
    logic                BNE;
    logic                ZERO;
    logic [OFFSET_W-1:0] OFFSET;
    logic [31:0]         PC;
    logic                PC_VALID;
    logic                TAKEN;

    modport master (
        output BUSYWAIT, JUMP, BEQ, BNE, ZERO, OFFSET,
        input  PC, PC_VALID, TAKEN
    );

    modport slave (
        input  BUSYWAIT, JUMP, BEQ, BNE, ZERO, OFFSET,
        output PC, PC_VALID, TAKEN
    );

endinterface

// File: rtl/branch_target_gen.sv
// branch_target_gen -- combinational PC-relative target adder.
//   seq    : in,  32 -- sequential address (PC + PC_STEP)
//   offset : in,  OFFSET_W -- signed word offset
//   tgt    : out, 32 -- seq + (sign-extended offset << 2), modulo 2^32
module branch_target_gen
    import pc_pkg::*;
(
    input  logic [31:0]         seq,
    input  logic [OFFSET_W-1:0] offset,
    output logic [31:0]         tgt
);

    logic [29:0] offset_words;

    always_comb begin
        offset_words = {{(30 - OFFSET_W){offset[OFFSET_W-1]}}, offset};
        tgt          = seq + {offset_words, 2'b00};
    end

endmodule

// File: rtl/pc_update_unit.sv
// pc_update_unit -- program counter sequencer with stall and PC-relative
// jump/branch redirects.
//   CLK          : in,  1  -- rising-edge clock
//   RESET        : in,  1  -- synchronous active-high reset
//   bus          : pc_update_unit_if.slave (controls in, PC/PC_VALID/TAKEN out)
//   BRANCH_COUNT : out, 16 -- taken-redirect counter, only with
//                  PC_BRANCH_STATS_EN defined
// Parameter RESET_PC gives the PC loaded on reset.
// Optional feature macro: PC_BRANCH_STATS_EN.
module pc_update_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RESET,
    pc_update_unit_if.slave bus
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [15:0]   BRANCH_COUNT
`endif
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        taken_q, taken_d;
    logic [31:0] seq_addr;
    logic [31:0] tgt_addr;
    logic        redirect;

    assign seq_addr = pc_q + 32'(PC_STEP);

    branch_target_gen u_branch_target_gen (
        .seq    (seq_addr),
        .offset (bus.OFFSET),
        .tgt    (tgt_addr)
    );

    assign redirect = redirect_taken(bus.JUMP, bus.BEQ, bus.BNE, bus.ZERO);

    // BOOT only arms the sequencer; PC first advances on the edge after
    // leaving BOOT. The edge that releases a stall samples the controls
    // like a normal RUN edge; nothing seen during the stall is kept.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = bus.BUSYWAIT ? STALL : RUN;
            end
            RUN, STALL: begin
                if (bus.BUSYWAIT) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                    pc_d    = redirect ? tgt_addr : seq_addr;
                    taken_d = redirect;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    assign bus.PC       = pc_q;
    assign bus.PC_VALID = (state_q != BOOT);
    assign bus.TAKEN    = taken_q;

`ifdef PC_BRANCH_STATS_EN
    logic [15:0] branch_count_q;

    always_ff @(posedge CLK) begin
        if (RESET)
            branch_count_q <= '0;
        else if (taken_d)
            branch_count_q <= branch_count_q + 16'd1;
    end

    assign BRANCH_COUNT = branch_count_q;
`endif

endmodule
